// File: rtl/router_pkg.sv
// Shared types for the router output-port collector: byte entry, FSM state, byte width.
package router_pkg;

  localparam int BYTE_W = 8;

  typedef struct packed {
    logic [BYTE_W-1:0] data;
    logic              last;
    logic              err;
  } byte_entry_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RECV = 1'b1
  } state_t;

endpackage

// File: rtl/router_byte_fifo.sv
// Small synchronous FIFO of byte entries. Full/empty come from an extra pointer wrap bit;
// a write while full is accepted only when a pop happens in the same cycle.
module router_byte_fifo #(
  parameter int  DEPTH = 4,
  parameter type T     = router_pkg::byte_entry_t
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr_en,
  input  T     i_wr_data,
  input  logic i_rd_en,
  output T     o_rd_data,
  output logic o_empty,
  output logic o_full,
  output logic o_wr_accept
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] r_wr_ptr;
  logic [AW:0] r_rd_ptr;
  T            r_mem [DEPTH];
  logic        w_pop;

  assign o_empty     = (r_wr_ptr == r_rd_ptr);
  assign o_full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign w_pop       = i_rd_en && !o_empty;
  assign o_wr_accept = i_wr_en && (!o_full || w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (o_wr_accept) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)       r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (o_wr_accept) r_mem[r_wr_ptr[AW-1:0]] <= i_wr_data;
  end

  // Head is forced to zero when empty so the outputs read zero out of reset.
  always_comb begin
    o_rd_data = '0;
    if (!o_empty) o_rd_data = r_mem[r_rd_ptr[AW-1:0]];
  end

endmodule

// File: rtl/router_port_collector.sv
// Deserialises one router output port (dout/frameo_n/valido_n) into byte entries,
// queues them in a FIFO with valid/ready drain, and counts cleanly ended packets.
module router_port_collector
  import router_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             dout,
  input  logic             frameo_n,
  input  logic             valido_n,
  output logic [7:0]       out_data,
  output logic             out_last,
  output logic             out_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pkt_count,
  output logic             overflow,
  output state_t           dbg_state
);

  // Drain handshake: an entry leaves the FIFO on a rising edge where out_valid and
  // out_ready are both 1; head fields are combinational and hold while out_ready is 0.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_bit_cnt;
  logic [2:0]       w_cnt_nxt;
  logic [7:0]       r_shift;
  logic [7:0]       w_shift_nxt;
  logic [7:0]       w_byte;
  logic             r_frame_prev;
  logic             w_collect;
  logic             w_push;
  byte_entry_t      w_push_entry;
  logic             r_push;
  byte_entry_t      r_push_entry;
  byte_entry_t      w_head;
  logic             w_empty;
  logic             w_full;
  logic             w_wr_accept;
  logic [CNT_W-1:0] r_pkt_count;
  logic             r_overflow;

  // Bits land at their final position so a partial byte is already zero-extended.
  assign w_byte = r_shift | ({7'd0, dout} << r_bit_cnt);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_bit_cnt;
    w_shift_nxt  = r_shift;
    w_collect    = 1'b0;
    w_push       = 1'b0;
    w_push_entry = '0;
    case (r_state)
      ST_IDLE: begin
        // Start only on a genuine falling frame, never mid-packet after reset.
        if (!frameo_n && r_frame_prev) begin
          w_state_nxt = ST_RECV;
          w_collect   = 1'b1;
        end
      end
      ST_RECV: w_collect = 1'b1;
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_collect) begin
      if (!valido_n) begin
        if (r_bit_cnt == 3'd7) begin
          w_push            = 1'b1;
          w_push_entry.data = w_byte;
          w_push_entry.last = frameo_n;
          w_push_entry.err  = 1'b0;
          w_shift_nxt       = '0;
          w_cnt_nxt         = '0;
        end else if (frameo_n) begin
          w_push            = 1'b1;
          w_push_entry.data = w_byte;
          w_push_entry.last = 1'b1;
          w_push_entry.err  = 1'b1;
        end else begin
          w_shift_nxt = w_byte;
          w_cnt_nxt   = r_bit_cnt + 3'd1;
        end
        if (frameo_n) w_state_nxt = ST_IDLE;
      end else if (frameo_n) begin
        w_push            = 1'b1;
        w_push_entry.data = r_shift;
        w_push_entry.last = 1'b1;
        w_push_entry.err  = 1'b1;
        w_state_nxt       = ST_IDLE;
      end
    end
    if (w_state_nxt == ST_IDLE) begin
      w_cnt_nxt   = '0;
      w_shift_nxt = '0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_frame_prev <= 1'b0;
      r_push       <= 1'b0;
      r_push_entry <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_bit_cnt    <= w_cnt_nxt;
      r_shift      <= w_shift_nxt;
      r_frame_prev <= frameo_n;
      r_push       <= w_push;
      r_push_entry <= w_push_entry;
    end
  end

  router_byte_fifo #(
    .DEPTH (FIFO_DEPTH),
    .T     (byte_entry_t)
  ) u_fifo (
    .clk         (clock),
    .rst         (reset),
    .i_wr_en     (r_push),
    .i_wr_data   (r_push_entry),
    .i_rd_en     (out_ready),
    .o_rd_data   (w_head),
    .o_empty     (w_empty),
    .o_full      (w_full),
    .o_wr_accept (w_wr_accept)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_pkt_count <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_wr_accept && r_push_entry.last && !r_push_entry.err)
        r_pkt_count <= r_pkt_count + CNT_W'(1);
      if (r_push && !w_wr_accept) r_overflow <= 1'b1;
    end
  end

  assign out_data  = w_head.data;
  assign out_last  = w_head.last;
  assign out_err   = w_head.err;
  assign out_valid = !w_empty;
  assign pkt_count = r_pkt_count;
  assign overflow  = r_overflow;
  assign dbg_state = r_state;

  logic w_unused;
  assign w_unused = w_full;

endmodule

// File: tb/tb_router_port_collector.sv
// Directed bench for router_port_collector: serial driver, drain monitor with expected queue.
module tb_router_port_collector;
  import router_pkg::*;

  logic        clock;
  logic        reset;
  logic        dout;
  logic        frameo_n;
  logic        valido_n;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_err;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] pkt_count;
  logic        overflow;
  state_t      dbg_state;

  int checks   = 0;
  int failures = 0;
  logic [9:0] exp_q[$];

  router_port_collector #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clock     (clock),
    .reset     (reset),
    .dout      (dout),
    .frameo_n  (frameo_n),
    .valido_n  (valido_n),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pkt_count (pkt_count),
    .overflow  (overflow),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // driver tasks: inputs change on the falling edge
  task automatic send_bit(input logic b, input logic fr_n);
    @(negedge clock);
    dout = b; frameo_n = fr_n; valido_n = 1'b0;
  endtask

  task automatic idle_bit();
    @(negedge clock);
    dout = 1'b0; frameo_n = 1'b0; valido_n = 1'b1;
  endtask

  task automatic rest(input logic rdy);
    @(negedge clock);
    dout = 1'b0; frameo_n = 1'b1; valido_n = 1'b1; out_ready = rdy;
  endtask

  task automatic send_packet(input logic [63:0] bits, input int nbits, input bit gap);
    for (int i = 0; i < nbits; i++) begin
      send_bit(bits[i], (i == nbits - 1));
      if (gap && i < nbits - 1) idle_bit();
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clock);
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  // scoreboard: every accepted head entry is compared against the expected queue
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_pop", exp_q.size(), 1);
        else check("entry", {out_data, out_last, out_err}, exp_q.pop_front());
      end
    end
  end

  initial begin
    reset = 1'b1; dout = 1'b0; frameo_n = 1'b1; valido_n = 1'b1; out_ready = 1'b0;
    repeat (2) @(negedge clock);
    #1;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_err", out_err, 0);
    check("rst_pkt_count", pkt_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(negedge clock);
    reset = 1'b0;
    rest(1'b1);

    // two-byte packet, back to back bits
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    send_packet({48'd0, 8'h3C, 8'hA5}, 16, 1'b0);
    rest(1'b1);
    drain();
    check("pkt_count_a", pkt_count, 1);

    // same packet with idle cycles between bits
    exp_q.push_back({8'hA5, 1'b0, 1'b0});
    exp_q.push_back({8'h3C, 1'b1, 1'b0});
    send_packet({48'd0, 8'h3C, 8'hA5}, 16, 1'b1);
    rest(1'b1);
    drain();
    check("pkt_count_gap", pkt_count, 2);

    // truncated frame: 0xFF then three bits 1,0,1
    exp_q.push_back({8'hFF, 1'b0, 1'b0});
    exp_q.push_back({8'h05, 1'b1, 1'b1});
    send_packet({53'd0, 3'b101, 8'hFF}, 11, 1'b0);
    rest(1'b1);
    drain();
    check("pkt_count_trunc", pkt_count, 2);

    // six bytes into a 4-deep FIFO with consumer stalled
    rest(1'b0);
    send_packet({16'd0, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11}, 48, 1'b0);
    rest(1'b0);
    repeat (4) @(negedge clock);
    #1;
    check("ovf_valid", out_valid, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_head", out_data, 8'h11);
    exp_q.push_back({8'h11, 1'b0, 1'b0});
    exp_q.push_back({8'h22, 1'b0, 1'b0});
    exp_q.push_back({8'h33, 1'b0, 1'b0});
    exp_q.push_back({8'h44, 1'b0, 1'b0});
    rest(1'b1);
    drain();
    check("ovf_empty", out_valid, 0);
    check("ovf_pkt_count", pkt_count, 2);
    check("ovf_sticky", overflow, 1);

    do_reset();
    #1;
    check("rst2_overflow", overflow, 0);
    check("rst2_pkt_count", pkt_count, 0);

    // full FIFO, single pop exactly on the cycle the fifth byte is written
    rest(1'b0);
    exp_q.push_back({8'hA1, 1'b0, 1'b0});
    exp_q.push_back({8'hA2, 1'b0, 1'b0});
    exp_q.push_back({8'hA3, 1'b0, 1'b0});
    exp_q.push_back({8'hA4, 1'b0, 1'b0});
    exp_q.push_back({8'hA5, 1'b1, 1'b0});
    send_packet({24'd0, 8'hA5, 8'hA4, 8'hA3, 8'hA2, 8'hA1}, 40, 1'b0);
    rest(1'b1);
    rest(1'b0);
    repeat (2) @(negedge clock);
    #1;
    check("simul_overflow", overflow, 0);
    check("simul_pending", exp_q.size(), 4);
    rest(1'b1);
    drain();
    check("simul_pkt_count", pkt_count, 1);

    // reset in the middle of a packet
    for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check("mid_rst_state", dbg_state, ST_IDLE);
    check("mid_rst_pkt_count", pkt_count, 0);
    check("mid_rst_valid", out_valid, 0);
    repeat (2) @(negedge clock);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) send_bit(1'b1, 1'b0);
    @(negedge clock);
    #1;
    check("post_rst_state", dbg_state, ST_IDLE);
    check("post_rst_valid", out_valid, 0);
    rest(1'b1);
    exp_q.push_back({8'h81, 1'b1, 1'b0});
    send_packet({56'd0, 8'h81}, 8, 1'b0);
    rest(1'b1);
    drain();
    check("final_pkt_count", pkt_count, 1);
    check("final_exp_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
